// File: rtl/vi_mmu_pkg.sv
// rtl/vi_mmu_pkg.sv - shared MMU types and widths for the data and instruction TLBs
package vi_mmu_pkg;

  localparam int PAGE_OFFSET_W = 12;
  localparam int VADDR_W       = 32;
  localparam int VPN_W_DEF     = VADDR_W - PAGE_OFFSET_W;
  localparam int PPN_W_DEF     = 20;

  // Miss handling: IDLE translates, MISS holds the core until the pipe is flushed
  typedef enum logic {
    DTLB_IDLE = 1'b0,
    DTLB_MISS = 1'b1
  } dtlb_state_e;

  // One translation at the default widths
  typedef struct packed {
    logic                 valid;
    logic [VPN_W_DEF-1:0] vpn;
    logic [PPN_W_DEF-1:0] ppn;
  } tlb_entry_t;

endpackage

// File: rtl/tlb_cam.sv
// rtl/tlb_cam.sv - fully-associative translation table with dedup write and round-robin victim
module tlb_cam #(
  parameter int ENTRIES = 4,
  parameter int VPN_W   = 20,
  parameter int PPN_W   = 20
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [VPN_W-1:0] lookup_vpn_i,
  output logic             lookup_hit_o,
  output logic [PPN_W-1:0] lookup_ppn_o,
  input  logic             wr_en_i,
  input  logic [VPN_W-1:0] wr_vpn_i,
  input  logic [PPN_W-1:0] wr_ppn_i
);

  localparam int IDX_W = $clog2(ENTRIES);

  logic [ENTRIES-1:0] valid_q;
  logic [VPN_W-1:0]   vpn_q [ENTRIES];
  logic [PPN_W-1:0]   ppn_q [ENTRIES];
  logic [IDX_W-1:0]   rr_q;

  logic               wr_match;
  logic [IDX_W-1:0]   wr_idx;

  // Lookup: at most one entry can match, so OR-ing the matching PPNs is a mux
  always_comb begin
    lookup_hit_o = 1'b0;
    lookup_ppn_o = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (valid_q[i] && (vpn_q[i] == lookup_vpn_i)) begin
        lookup_hit_o = 1'b1;
        lookup_ppn_o = lookup_ppn_o | ppn_q[i];
      end
    end
  end

  // Write-side match finds an existing entry for the VPN so it is updated, not duplicated
  always_comb begin
    wr_match = 1'b0;
    wr_idx   = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (valid_q[i] && (vpn_q[i] == wr_vpn_i)) begin
        wr_match = 1'b1;
        wr_idx   = IDX_W'(i);
      end
    end
  end

  // Table update: overwrite PPN on match, otherwise fill the victim and advance the pointer
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= '0;
      rr_q    <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        vpn_q[i] <= '0;
        ppn_q[i] <= '0;
      end
    end else if (wr_en_i) begin
      if (wr_match) begin
        ppn_q[wr_idx] <= wr_ppn_i;
      end else begin
        valid_q[rr_q] <= 1'b1;
        vpn_q[rr_q]   <= wr_vpn_i;
        ppn_q[rr_q]   <= wr_ppn_i;
        rr_q          <= rr_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/tl_dtlb.sv
// rtl/tl_dtlb.sv - TL-stage data TLB: translation, miss FSM, tlbwrite and ITLB fill forwarding
module tl_dtlb
  import vi_mmu_pkg::*;
#(
  parameter int ENTRIES = 4,
  parameter int VPN_W   = VPN_W_DEF,
  parameter int PPN_W   = PPN_W_DEF
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             kill_i,
  input  logic             supervisor_i,
  input  logic             tl_cache_enable_i,
  input  logic [31:0]      tl_cache_addr_i,
  input  logic             tl_tlbwrite_i,
  input  logic             tl_idtlb_i,
  input  logic [31:0]      tl_read_data_a_i,
  input  logic [31:0]      tl_read_data_b_i,
  output logic             dc_req_o,
  output logic [31:0]      dc_paddr_o,
  output logic             stall_core_o,
  output logic             exc_dtlb_miss_o,
  output logic [31:0]      miss_vaddr_o,
  output logic             itlb_wr_o,
  output logic [VPN_W-1:0] itlb_wr_vpn_o,
  output logic [PPN_W-1:0] itlb_wr_ppn_o
);

  dtlb_state_e state_q;
  logic        exc_q;
  logic [31:0] miss_vaddr_q;

  logic                           hit;
  logic [PPN_W-1:0]               hit_ppn;
  logic                           is_idle;
  logic                           access;
  logic                           miss_now;
  logic                           dtlb_wr;
  logic [PPN_W+PAGE_OFFSET_W-1:0] xlated;
  logic                           unused_offsets;

  // A killed or stalled instruction must neither translate nor update any table
  assign is_idle  = (state_q == DTLB_IDLE);
  assign access   = is_idle && tl_cache_enable_i && !kill_i;
  assign miss_now = access && !supervisor_i && !hit;
  assign dtlb_wr  = is_idle && tl_tlbwrite_i && !tl_idtlb_i && !kill_i;

  // Lookup sees the table as it was before any same-cycle write lands
  tlb_cam #(
    .ENTRIES (ENTRIES),
    .VPN_W   (VPN_W),
    .PPN_W   (PPN_W)
  ) u_cam (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .lookup_vpn_i (tl_cache_addr_i[PAGE_OFFSET_W +: VPN_W]),
    .lookup_hit_o (hit),
    .lookup_ppn_o (hit_ppn),
    .wr_en_i      (dtlb_wr),
    .wr_vpn_i     (tl_read_data_a_i[PAGE_OFFSET_W +: VPN_W]),
    .wr_ppn_i     (tl_read_data_b_i[PAGE_OFFSET_W +: PPN_W])
  );

  // Zero-latency data-cache request; supervisor mode passes the VA through untouched
  assign xlated       = {hit_ppn, tl_cache_addr_i[PAGE_OFFSET_W-1:0]};
  assign dc_req_o     = access && (supervisor_i || hit);
  assign dc_paddr_o   = supervisor_i ? tl_cache_addr_i : 32'(xlated);
  assign stall_core_o = (state_q == DTLB_MISS) || miss_now;

  // ITLB fills bypass this table and go straight out for one cycle
  assign itlb_wr_o     = is_idle && tl_tlbwrite_i && tl_idtlb_i && !kill_i;
  assign itlb_wr_vpn_o = tl_read_data_a_i[PAGE_OFFSET_W +: VPN_W];
  assign itlb_wr_ppn_o = tl_read_data_b_i[PAGE_OFFSET_W +: PPN_W];

  assign unused_offsets = ^{tl_read_data_a_i[PAGE_OFFSET_W-1:0],
                            tl_read_data_b_i[PAGE_OFFSET_W-1:0]};

  // Miss FSM: capture the faulting VA, raise the exception, wait for the flush
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= DTLB_IDLE;
      exc_q        <= 1'b0;
      miss_vaddr_q <= '0;
    end else begin
      case (state_q)
        DTLB_IDLE: begin
          if (miss_now) begin
            state_q      <= DTLB_MISS;
            exc_q        <= 1'b1;
            miss_vaddr_q <= tl_cache_addr_i;
          end
        end
        DTLB_MISS: begin
          if (kill_i) begin
            state_q <= DTLB_IDLE;
            exc_q   <= 1'b0;
          end
        end
        default: begin
          state_q <= DTLB_IDLE;
          exc_q   <= 1'b0;
        end
      endcase
    end
  end

  assign exc_dtlb_miss_o = exc_q;
  assign miss_vaddr_o    = miss_vaddr_q;

endmodule

// File: tb/tb_tl_dtlb.sv
// tb/tb_tl_dtlb.sv - scoreboard bench for tl_dtlb with directed vectors
module tb_tl_dtlb;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        kill_i = 1'b0;
  logic        supervisor_i = 1'b0;
  logic        tl_cache_enable_i = 1'b0;
  logic [31:0] tl_cache_addr_i = '0;
  logic        tl_tlbwrite_i = 1'b0;
  logic        tl_idtlb_i = 1'b0;
  logic [31:0] tl_read_data_a_i = '0;
  logic [31:0] tl_read_data_b_i = '0;
  logic        dc_req_o;
  logic [31:0] dc_paddr_o;
  logic        stall_core_o;
  logic        exc_dtlb_miss_o;
  logic [31:0] miss_vaddr_o;
  logic        itlb_wr_o;
  logic [19:0] itlb_wr_vpn_o;
  logic [19:0] itlb_wr_ppn_o;

  always #5 clk_i = ~clk_i;

  tl_dtlb #(.ENTRIES(4), .VPN_W(20), .PPN_W(20)) dut (
    .clk_i             (clk_i),
    .rst_i             (rst_i),
    .kill_i            (kill_i),
    .supervisor_i      (supervisor_i),
    .tl_cache_enable_i (tl_cache_enable_i),
    .tl_cache_addr_i   (tl_cache_addr_i),
    .tl_tlbwrite_i     (tl_tlbwrite_i),
    .tl_idtlb_i        (tl_idtlb_i),
    .tl_read_data_a_i  (tl_read_data_a_i),
    .tl_read_data_b_i  (tl_read_data_b_i),
    .dc_req_o          (dc_req_o),
    .dc_paddr_o        (dc_paddr_o),
    .stall_core_o      (stall_core_o),
    .exc_dtlb_miss_o   (exc_dtlb_miss_o),
    .miss_vaddr_o      (miss_vaddr_o),
    .itlb_wr_o         (itlb_wr_o),
    .itlb_wr_vpn_o     (itlb_wr_vpn_o),
    .itlb_wr_ppn_o     (itlb_wr_ppn_o)
  );

  typedef struct {
    int          id;
    logic        rst, en, tw, idt, kill, sup;
    logic [31:0] addr, a, b;
    logic        e_req, chk_pa, e_stall, e_exc, chk_mv, e_iw, chk_idat;
    logic [31:0] e_pa, e_mv;
    logic [19:0] e_ivpn, e_ippn;
  } vec_t;

  vec_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   sid   = 0;

  task automatic chk(input int id, input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL step%0d %s got=%h exp=%h", id, nm, got, exp);
    end
  endtask

  // Monitor: each cycle's response is compared against the queued expectation
  initial begin
    vec_t v;
    forever begin
      @(negedge clk_i);
      if (exp_q.size() > 0) begin
        v = exp_q.pop_front();
        chk(v.id, "dc_req", 32'(dc_req_o), 32'(v.e_req));
        if (v.chk_pa) chk(v.id, "dc_paddr", dc_paddr_o, v.e_pa);
        chk(v.id, "stall", 32'(stall_core_o), 32'(v.e_stall));
        chk(v.id, "exc", 32'(exc_dtlb_miss_o), 32'(v.e_exc));
        chk(v.id, "itlb_wr", 32'(itlb_wr_o), 32'(v.e_iw));
        if (v.chk_mv) chk(v.id, "miss_vaddr", miss_vaddr_o, v.e_mv);
        if (v.chk_idat) begin
          chk(v.id, "itlb_vpn", 32'(itlb_wr_vpn_o), 32'(v.e_ivpn));
          chk(v.id, "itlb_ppn", 32'(itlb_wr_ppn_o), 32'(v.e_ippn));
        end
      end
    end
  end

  function automatic vec_t mk();
    vec_t v;
    v = '{default: 0};
    return v;
  endfunction

  task automatic step(input vec_t v);
    @(posedge clk_i);
    #1;
    rst_i             = v.rst;
    tl_cache_enable_i = v.en;
    tl_cache_addr_i   = v.addr;
    tl_tlbwrite_i     = v.tw;
    tl_idtlb_i        = v.idt;
    tl_read_data_a_i  = v.a;
    tl_read_data_b_i  = v.b;
    kill_i            = v.kill;
    supervisor_i      = v.sup;
    v.id = sid;
    sid++;
    exp_q.push_back(v);
  endtask

  task automatic reset_step();
    vec_t v;
    v = mk();
    v.rst = 1'b1; v.chk_pa = 1'b1; v.chk_mv = 1'b1; v.chk_idat = 1'b1;
    step(v);
  endtask

  task automatic idle_nop();
    vec_t v;
    v = mk();
    v.chk_pa = 1'b1;
    step(v);
  endtask

  task automatic load(input logic [31:0] addr, input logic sup, input logic kill,
                      input logic e_req, input logic [31:0] e_pa, input logic e_stall);
    vec_t v;
    v = mk();
    v.en = 1'b1; v.addr = addr; v.sup = sup; v.kill = kill;
    v.e_req = e_req; v.chk_pa = e_req; v.e_pa = e_pa; v.e_stall = e_stall;
    step(v);
  endtask

  task automatic miss_hold(input logic [31:0] mv, input logic kill);
    vec_t v;
    v = mk();
    v.kill = kill; v.e_stall = 1'b1; v.e_exc = 1'b1; v.chk_mv = 1'b1; v.e_mv = mv;
    step(v);
  endtask

  task automatic miss_seq(input logic [31:0] addr);
    load(addr, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    miss_hold(addr, 1'b0);
    miss_hold(addr, 1'b1);
    idle_nop();
  endtask

  task automatic twrite(input logic [31:0] a, input logic [31:0] b, input logic idt,
                        input logic [19:0] e_ivpn, input logic [19:0] e_ippn);
    vec_t v;
    v = mk();
    v.tw = 1'b1; v.a = a; v.b = b; v.idt = idt;
    v.e_iw = idt; v.chk_idat = idt; v.e_ivpn = e_ivpn; v.e_ippn = e_ippn;
    step(v);
  endtask

  initial begin
    vec_t v;
    int   guard;

    reset_step();
    idle_nop();

    // Cold miss, exception next cycle, flushed by kill
    miss_seq(32'h0000_5123);

    // Fill then hit
    twrite(32'h0000_5000, 32'h0008_7000, 1'b0, 20'h0, 20'h0);
    load(32'h0000_5123, 1'b0, 1'b0, 1'b1, 32'h0008_7123, 1'b0);

    // Reset in the middle of a miss clears the table and the FSM
    load(32'h0000_9000, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    miss_hold(32'h0000_9000, 1'b0);
    reset_step();
    idle_nop();
    miss_seq(32'h0000_5123);

    // Supervisor bypass with an empty table
    load(32'hDEAD_BEEC, 1'b1, 1'b0, 1'b1, 32'hDEAD_BEEC, 1'b0);
    idle_nop();

    // Kill in IDLE suppresses request and miss detection
    load(32'h0000_4444, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    idle_nop();

    // Five distinct fills into four entries: VPN 1 is evicted
    for (int i = 1; i <= 5; i++)
      twrite(32'(i) << 12, (32'h100 + 32'(i)) << 12, 1'b0, 20'h0, 20'h0);
    miss_seq(32'h0000_1ABC);
    load(32'h0000_2ABC, 1'b0, 1'b0, 1'b1, 32'h0010_2ABC, 1'b0);
    load(32'h0000_3ABC, 1'b0, 1'b0, 1'b1, 32'h0010_3ABC, 1'b0);
    load(32'h0000_4ABC, 1'b0, 1'b0, 1'b1, 32'h0010_4ABC, 1'b0);
    load(32'h0000_5ABC, 1'b0, 1'b0, 1'b1, 32'h0010_5ABC, 1'b0);

    // Rewrite VPN 3: new PPN, pointer stays, so the next new VPN evicts VPN 2
    twrite(32'h0000_3000, 32'h0033_3000, 1'b0, 20'h0, 20'h0);
    load(32'h0000_3004, 1'b0, 1'b0, 1'b1, 32'h0033_3004, 1'b0);
    twrite(32'h0000_6000, 32'h0010_6000, 1'b0, 20'h0, 20'h0);
    miss_seq(32'h0000_2ABC);
    load(32'h0000_3004, 1'b0, 1'b0, 1'b1, 32'h0033_3004, 1'b0);
    load(32'h0000_6ABC, 1'b0, 1'b0, 1'b1, 32'h0010_6ABC, 1'b0);

    // Write and lookup of the same VPN in one cycle: lookup sees the old table
    v = mk();
    v.en = 1'b1; v.addr = 32'h0000_7000; v.tw = 1'b1;
    v.a = 32'h0000_7000; v.b = 32'h0010_7000; v.e_stall = 1'b1;
    step(v);
    // tlbwrite during MISS is dropped
    v = mk();
    v.tw = 1'b1; v.a = 32'h0000_8000; v.b = 32'h0010_8000;
    v.e_stall = 1'b1; v.e_exc = 1'b1; v.chk_mv = 1'b1; v.e_mv = 32'h0000_7000;
    step(v);
    miss_hold(32'h0000_7000, 1'b1);
    idle_nop();
    load(32'h0000_7010, 1'b0, 1'b0, 1'b1, 32'h0010_7010, 1'b0);
    miss_seq(32'h0000_8000);

    // ITLB forwarding: one-cycle strobe, DTLB untouched
    twrite(32'h1234_5000, 32'h000A_B000, 1'b1, 20'h12345, 20'h000AB);
    idle_nop();
    miss_seq(32'h1234_5000);

    guard = 0;
    while (exp_q.size() > 0 && guard < 20) begin
      @(negedge clk_i);
      guard++;
    end
    #2;
    if (exp_q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain pending=%0d exp=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tl_dtlb.md
# tl_dtlb

Data TLB for the TL (translation/lookup) stage. It consumes the registered EXE→TL stage outputs and translates load/store virtual addresses into physical addresses for the data cache. It also executes `tlbwrite` instructions, filling its own entries or forwarding fills to the ITLB. It holds a small fully-associative table with round-robin replacement and a miss state machine that stalls the core until the exception path flushes the pipe.

## Interface
Parameters:
- `ENTRIES`, default 4: number of TLB entries, power of two, ≥2.
- `VPN_W`, default 20: virtual page number width; 4 KiB pages, 12-bit offset.
- `PPN_W`, default 20: physical page number width.

Ports:
- `clk_i` in 1: clock.
- `rst_i` in 1: reset, asynchronous, active-high.
- `kill_i` in 1: pipeline flush from the exception unit.
- `supervisor_i` in 1: 1 = translation bypassed (PA = VA).
- `tl_cache_enable_i` in 1: TL stage holds a load/store.
- `tl_cache_addr_i` in 32: virtual address.
- `tl_tlbwrite_i` in 1: TL stage holds a tlbwrite.
- `tl_idtlb_i` in 1: tlbwrite target, 0 = DTLB, 1 = ITLB.
- `tl_read_data_a_i` in 32: tlbwrite virtual address; VPN = [31:12].
- `tl_read_data_b_i` in 32: tlbwrite physical address; PPN = [31:12].
- `dc_req_o` out 1: valid translated request to the data cache.
- `dc_paddr_o` out 32: physical address, `{ppn, vaddr[11:0]}`.
- `stall_core_o` out 1: freeze all upstream latches.
- `exc_dtlb_miss_o` out 1: DTLB miss exception request.
- `miss_vaddr_o` out 32: faulting virtual address.
- `itlb_wr_o` out 1: ITLB fill strobe.
- `itlb_wr_vpn_o` out VPN_W: ITLB fill VPN.
- `itlb_wr_ppn_o` out PPN_W: ITLB fill PPN.

## Operation
- Entry fields: `valid`, `vpn[VPN_W]`, `ppn[PPN_W]`. A round-robin pointer `rr[log2(ENTRIES)]` selects the replacement victim.
- Lookup is combinational over all entries. A hit requires `valid && vpn == tl_cache_addr_i[31:12]`. Multiple hits cannot happen because the write path de-duplicates.
- FSM states are IDLE and MISS.
- In IDLE with `tl_cache_enable_i`:
  - `supervisor_i=1`: `dc_req_o=1`, `dc_paddr_o=tl_cache_addr_i`.
  - Hit: `dc_req_o=1`, `dc_paddr_o={ppn, offset}`.
  - Miss: `dc_req_o=0`, `stall_core_o=1` in the same cycle. The FSM moves to MISS and captures `miss_vaddr_o`.
- In MISS: `stall_core_o=1`, `exc_dtlb_miss_o=1`, `dc_req_o=0`, and `miss_vaddr_o` is held. `kill_i` returns the FSM to IDLE on the next edge. Without `kill_i` the FSM stays in MISS indefinitely.
- `kill_i` in IDLE: `dc_req_o=0`, no miss is detected, and no state change occurs.
- tlbwrite in IDLE with `tl_idtlb_i=0` and `!kill_i`:
  - If the VPN is already present, that entry's PPN is overwritten and `rr` is unchanged.
  - Otherwise entry `rr` is written with `valid=1`, and `rr` increments modulo ENTRIES.
- tlbwrite with `tl_idtlb_i=1`: `itlb_wr_o=1` for that one cycle, with VPN/PPN driven combinationally from data a/b. The DTLB is untouched.
- If tlbwrite and cache_enable are both asserted, the write is performed and the lookup uses the pre-write contents.
- tlbwrite is ignored in MISS.

## Timing
- Translation latency: 0 cycles. `dc_*` are valid in the same cycle as the `tl_*` inputs.
- Table write: visible to lookups from the cycle after the write edge.
- Miss at cycle N:
  - `stall_core_o=1` at N.
  - `exc_dtlb_miss_o=1` from N+1 until `kill_i` is sampled.
  - IDLE is reached one cycle after `kill_i`.
- Reset, including reset during MISS: asynchronous entry to IDLE with the following values.
  - All `valid=0`, `rr=0`.
  - `miss_vaddr_o=0`.
  - `dc_req_o=0`, `stall_core_o=0`, `exc_dtlb_miss_o=0`, `itlb_wr_o=0`.
  - `dc_paddr_o` and the ITLB data outputs read 0 while their inputs are 0.
- Pointer wrap: after ENTRIES fills of distinct VPNs, `rr=0` again and the oldest entry is evicted next.

## Structure
- Shared package `vi_mmu_pkg`: `PAGE_OFFSET_W=12`, VPN/PPN widths, the FSM state enum `{DTLB_IDLE, DTLB_MISS}`, and the TLB entry struct type. The ITLB reuses all of these.
- One sub-module, `tlb_cam`: an ENTRIES-deep table with a lookup port (hit, PPN), a write port, VPN-match de-duplication and the round-robin pointer. The ITLB reuses it.
- `tl_dtlb` contains the FSM, the bypass logic and the ITLB forwarding.

## Test plan
- Reset, then load at VA 0x0000_5123 with `supervisor_i=0` → `stall_core_o=1` same cycle; `exc_dtlb_miss_o=1`, `miss_vaddr_o=0x0000_5123` next cycle; `kill_i` pulse → IDLE, outputs 0.
- tlbwrite with a=0x0000_5000, b=0x0008_7000, idtlb=0; next cycle load at 0x0000_5123 → `dc_req_o=1`, `dc_paddr_o=0x0008_7123`, no stall.
- With ENTRIES=4:
  - Fill VPNs 1..5 in order → VPN 1 is evicted and misses; VPNs 2..5 hit.
  - Rewrite VPN 3 with a new PPN → `rr` unchanged and the lookup returns the new PPN.
- tlbwrite with idtlb=1, a=0x1234_5000, b=0x000A_B000 → `itlb_wr_o` 1-cycle pulse with VPN 0x12345 and PPN 0x000AB; the subsequent DTLB lookup of 0x1234_5000 misses.
- `supervisor_i=1` with an empty TLB, store at 0xDEAD_BEEC → `dc_paddr_o=0xDEAD_BEEC`, no miss.
- `rst_i` asserted mid-MISS → asynchronous clear to IDLE; a lookup of a previously valid VPN after reset misses.
